lcd_bus_responder: RTL and testbench

- Synthesizable responder for the 4-bit character-LCD write bus (LCD_E, LCD_RS, LCD_RW, SF_D) that the LCD controller drives.
- Decodes the power-on init handshake, pairs nibbles into bytes, executes the command subset the controller uses, and mirrors DDRAM contents into an 80-byte buffer.
- Used as an on-chip display mirror and loopback checker. A read port exposes the buffer, and sticky error flags report protocol and timing violations.

---
 rtl/lcd_pkg.sv | 65 ++++++
 rtl/lcd_ddram_buf.sv | 36 +++
 rtl/lcd_bus_responder.sv | 262 ++++++++++++++++++++++++++
 tb/tb_lcd_bus_responder.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD write-bus responder: states, opcodes,
// DDRAM geometry, controller timing defaults and address helpers.
package lcd_pkg;

  localparam int unsigned E_MIN_HIGH_DEF = 12;
  localparam int unsigned CMD_BUSY_DEF   = 2000;
  localparam int unsigned CLEAR_BUSY_DEF = 82000;

  localparam int unsigned ADDR_W    = 7;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned NIB_W     = 4;
  localparam int unsigned LINE_LEN  = 40;
  localparam int unsigned BUF_DEPTH = 2 * LINE_LEN;

  localparam logic [ADDR_W-1:0] LINE0_BASE = 7'h00;
  localparam logic [ADDR_W-1:0] LINE1_BASE = 7'h40;
  localparam logic [ADDR_W-1:0] LINE0_LAST = 7'h27;
  localparam logic [ADDR_W-1:0] LINE1_LAST = 7'h67;
  localparam logic [DATA_W-1:0] BLANK_CHAR = 8'h20;

  localparam logic [DATA_W-1:0] CMD_CLEAR = 8'h01;
  localparam logic [DATA_W-1:0] CMD_HOME  = 8'h02;
  localparam logic [DATA_W-1:0] CMD_ENTRY = 8'h04;
  localparam logic [DATA_W-1:0] CMD_DISP  = 8'h08;
  localparam logic [DATA_W-1:0] CMD_FUNC  = 8'h20;
  localparam logic [DATA_W-1:0] CMD_CGRAM = 8'h40;
  localparam logic [DATA_W-1:0] CMD_DDRAM = 8'h80;
  localparam logic [DATA_W-1:0] FUNC_DL8  = 8'h10;

  typedef enum logic [2:0] {
    ST_INIT_A,
    ST_INIT_B,
    ST_HIGH,
    ST_LOW,
    ST_CLEAR
  } lcd_state_e;

  typedef struct packed {
    logic             rw;
    logic             rs;
    logic [NIB_W-1:0] nib;
  } lcd_nib_t;

  // Line 1 (addr bit 6) occupies buffer indices 40..79.
  function automatic logic [ADDR_W-1:0] addr_to_idx(input logic [ADDR_W-1:0] addr);
    return addr[6] ? ADDR_W'(LINE_LEN) + ADDR_W'(addr[5:0]) : ADDR_W'(addr[5:0]);
  endfunction

  function automatic logic addr_legal(input logic [5:0] off);
    return off < 6'(LINE_LEN);
  endfunction

  function automatic logic [ADDR_W-1:0] addr_step(input logic [ADDR_W-1:0] addr,
                                                  input logic inc);
    if (inc) begin
      if (addr == LINE0_LAST) return LINE1_BASE;
      if (addr == LINE1_LAST) return LINE0_BASE;
      return addr + 7'd1;
    end
    if (addr == LINE0_BASE) return LINE1_LAST;
    if (addr == LINE1_BASE) return LINE0_LAST;
    return addr - 7'd1;
  endfunction

endpackage

// File: rtl/lcd_ddram_buf.sv
// 80x8 DDRAM mirror: one write port, one registered read port (read-before-write).
module lcd_ddram_buf
  import lcd_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [BUF_DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i && (waddr_i < ADDR_W'(BUF_DEPTH))) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Out-of-range indices read as blank.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= BLANK_CHAR;
    end else if (raddr_i < ADDR_W'(BUF_DEPTH)) begin
      rdata_q <= mem_q[raddr_i];
    end else begin
      rdata_q <= BLANK_CHAR;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/lcd_bus_responder.sv
// Responder for the 4-bit character-LCD write bus: init handshake, nibble pairing,
// command execution and a DDRAM mirror with sticky protocol/timing error flags.
module lcd_bus_responder
  import lcd_pkg::*;
#(
  parameter int unsigned E_MIN_HIGH = E_MIN_HIGH_DEF,
  parameter int unsigned CMD_BUSY   = CMD_BUSY_DEF,
  parameter int unsigned CLEAR_BUSY = CLEAR_BUSY_DEF
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              LCD_E,
  input  logic              LCD_RS,
  input  logic              LCD_RW,
  input  logic [NIB_W-1:0]  SF_D,
  output logic              mode4,
  output logic              busy,
  output logic              disp_on,
  output logic [ADDR_W-1:0] cursor_addr,
  output logic              byte_valid,
  output logic              byte_rs,
  output logic [DATA_W-1:0] byte_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              proto_err,
  output logic              timing_err
);

  localparam int unsigned BUSY_MAX = (CLEAR_BUSY > CMD_BUSY) ? CLEAR_BUSY : CMD_BUSY;
  localparam int unsigned BUSY_W   = $clog2(BUSY_MAX + 1);
  localparam int unsigned HCNT_W   = $clog2(E_MIN_HIGH + 2);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(BUF_DEPTH - 1);

  lcd_state_e        state_q, state_d;
  logic [1:0]        init_cnt_q, init_cnt_d;
  logic [NIB_W-1:0]  hi_q, hi_d;
  logic              e_q;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  lcd_nib_t          cap_q, cap_d;
  logic [BUSY_W-1:0] busy_cnt_q, busy_cnt_d;
  logic              busy_q, busy_d;
  logic              clr_active_q, clr_active_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
  logic              inc_q, inc_d;
  logic              mode4_q, mode4_d;
  logic              disp_on_q, disp_on_d;
  logic [ADDR_W-1:0] cursor_q, cursor_d;
  logic              bv_q, bv_d;
  logic              brs_q, brs_d;
  logic [DATA_W-1:0] bdata_q, bdata_d;
  logic              perr_q, perr_d;
  logic              terr_q, terr_d;

  logic              strobe_c, rise_c, short_c, rw_bad_c, accept_c;
  logic [DATA_W-1:0] byte_c;
  logic              buf_we_c;
  logic [ADDR_W-1:0] buf_waddr_c, rd_idx_c;
  logic [DATA_W-1:0] buf_wdata_c;

  assign strobe_c = e_q & ~LCD_E;
  assign rise_c   = LCD_E & ~e_q;
  assign short_c  = hcnt_q < HCNT_W'(E_MIN_HIGH);
  assign rw_bad_c = cap_q.rw | LCD_RW;
  assign accept_c = strobe_c & ~short_c & ~rw_bad_c & (state_q != ST_CLEAR);
  assign byte_c   = {hi_q, cap_q.nib};
  assign rd_idx_c = addr_to_idx(rd_addr);

  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    hi_d         = hi_q;
    hcnt_d       = hcnt_q;
    cap_d        = cap_q;
    busy_cnt_d   = busy_cnt_q;
    busy_d       = busy_q;
    clr_active_d = clr_active_q;
    clr_idx_d    = clr_idx_q;
    inc_d        = inc_q;
    mode4_d      = mode4_q;
    disp_on_d    = disp_on_q;
    cursor_d     = cursor_q;
    bv_d         = 1'b0;
    brs_d        = brs_q;
    bdata_d      = bdata_q;
    perr_d       = perr_q;
    terr_d       = terr_q;
    buf_we_c     = 1'b0;
    buf_waddr_c  = clr_idx_q;
    buf_wdata_c  = BLANK_CHAR;

    // Strobe capture: hold the last {RW, RS, nibble} seen while E is high.
    if (LCD_E) begin
      cap_d = lcd_nib_t'{rw: LCD_RW, rs: LCD_RS, nib: SF_D};
      if (!e_q) begin
        hcnt_d = HCNT_W'(1);
      end else if (hcnt_q != HCNT_W'(E_MIN_HIGH)) begin
        hcnt_d = hcnt_q + HCNT_W'(1);
      end
    end
    if (rise_c && busy_q) terr_d = 1'b1;
    if (strobe_c) begin
      if ((state_q == ST_CLEAR) || short_c) begin
        terr_d = 1'b1;
      end else if (rw_bad_c) begin
        perr_d = 1'b1;
      end
    end

    if (busy_cnt_q != '0) busy_cnt_d = busy_cnt_q - BUSY_W'(1);

    // Clear sequencer: blanks one buffer entry per cycle.
    if (clr_active_q) begin
      buf_we_c = 1'b1;
      if (clr_idx_q == LAST_IDX) begin
        clr_active_d = 1'b0;
      end else begin
        clr_idx_d = clr_idx_q + 7'd1;
      end
    end

    case (state_q)
      ST_INIT_A: begin
        if (accept_c) begin
          busy_cnt_d = BUSY_W'(CMD_BUSY);
          if (!cap_q.rs && (cap_q.nib == 4'h3)) begin
            init_cnt_d = init_cnt_q + 2'd1;
            if (init_cnt_q == 2'd2) state_d = ST_INIT_B;
          end else begin
            perr_d = 1'b1;
          end
        end
      end
      ST_INIT_B: begin
        if (accept_c) begin
          busy_cnt_d = BUSY_W'(CMD_BUSY);
          if (!cap_q.rs && (cap_q.nib == 4'h2)) begin
            mode4_d = 1'b1;
            state_d = ST_HIGH;
          end else begin
            perr_d = 1'b1;
          end
        end
      end
      ST_HIGH: begin
        if (accept_c) begin
          hi_d    = cap_q.nib;
          state_d = ST_LOW;
        end
      end
      ST_LOW: begin
        if (accept_c) begin
          state_d    = ST_HIGH;
          bv_d       = 1'b1;
          brs_d      = cap_q.rs;
          bdata_d    = byte_c;
          busy_cnt_d = BUSY_W'(CMD_BUSY);
          if (cap_q.rs) begin
            buf_we_c    = 1'b1;
            buf_waddr_c = addr_to_idx(cursor_q);
            buf_wdata_c = byte_c;
            cursor_d    = addr_step(cursor_q, inc_q);
          end else if ((byte_c & CMD_DDRAM) != '0) begin
            if (addr_legal(byte_c[5:0])) begin
              cursor_d = byte_c[6:0];
            end else begin
              cursor_d = {byte_c[6], 6'b0};
              perr_d   = 1'b1;
            end
          end else if ((byte_c & CMD_CGRAM) != '0) begin
            cursor_d = cursor_q;
          end else if ((byte_c & CMD_FUNC) != '0) begin
            if ((byte_c & FUNC_DL8) != '0) perr_d = 1'b1;
          end else if ((byte_c & CMD_DISP) != '0) begin
            disp_on_d = byte_c[2];
          end else if ((byte_c & CMD_ENTRY) != '0) begin
            inc_d = byte_c[1];
          end else if ((byte_c & CMD_HOME) != '0) begin
            cursor_d = LINE0_BASE;
          end else if ((byte_c & CMD_CLEAR) != '0) begin
            cursor_d     = LINE0_BASE;
            state_d      = ST_CLEAR;
            clr_active_d = 1'b1;
            clr_idx_d    = '0;
            busy_cnt_d   = BUSY_W'(CLEAR_BUSY);
          end
        end
      end
      ST_CLEAR: begin
        if (!clr_active_q || (clr_idx_q == LAST_IDX)) state_d = ST_HIGH;
      end
      default: state_d = ST_INIT_A;
    endcase

    busy_d = (busy_cnt_d != '0);
  end

  // Reset reruns the blanking sequence with busy asserted throughout.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= ST_INIT_A;
      init_cnt_q   <= '0;
      hi_q         <= '0;
      e_q          <= 1'b0;
      hcnt_q       <= '0;
      cap_q        <= '0;
      busy_cnt_q   <= BUSY_W'(BUF_DEPTH);
      busy_q       <= 1'b1;
      clr_active_q <= 1'b1;
      clr_idx_q    <= '0;
      inc_q        <= 1'b1;
      mode4_q      <= 1'b0;
      disp_on_q    <= 1'b0;
      cursor_q     <= LINE0_BASE;
      bv_q         <= 1'b0;
      brs_q        <= 1'b0;
      bdata_q      <= '0;
      perr_q       <= 1'b0;
      terr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      hi_q         <= hi_d;
      e_q          <= LCD_E;
      hcnt_q       <= hcnt_d;
      cap_q        <= cap_d;
      busy_cnt_q   <= busy_cnt_d;
      busy_q       <= busy_d;
      clr_active_q <= clr_active_d;
      clr_idx_q    <= clr_idx_d;
      inc_q        <= inc_d;
      mode4_q      <= mode4_d;
      disp_on_q    <= disp_on_d;
      cursor_q     <= cursor_d;
      bv_q         <= bv_d;
      brs_q        <= brs_d;
      bdata_q      <= bdata_d;
      perr_q       <= perr_d;
      terr_q       <= terr_d;
    end
  end

  lcd_ddram_buf u_buf (
    .clk_i   (Clock),
    .rst_i   (Reset),
    .we_i    (buf_we_c),
    .waddr_i (buf_waddr_c),
    .wdata_i (buf_wdata_c),
    .raddr_i (rd_idx_c),
    .rdata_o (rd_data)
  );

  assign mode4       = mode4_q;
  assign busy        = busy_q;
  assign disp_on     = disp_on_q;
  assign cursor_addr = cursor_q;
  assign byte_valid  = bv_q;
  assign byte_rs     = brs_q;
  assign byte_data   = bdata_q;
  assign proto_err   = perr_q;
  assign timing_err  = terr_q;

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Directed bench for lcd_bus_responder with shortened busy timings.
module tb_lcd_bus_responder;

  localparam int unsigned E_MIN   = 12;
  localparam int unsigned CMD_B   = 200;
  localparam int unsigned CLR_B   = 1000;
  localparam int          IDLE_TO = 5000;

  logic       Clock, Reset, LCD_E, LCD_RS, LCD_RW;
  logic [3:0] SF_D;
  logic       mode4, busy, disp_on, byte_valid, byte_rs, proto_err, timing_err;
  logic [6:0] cursor_addr, rd_addr;
  logic [7:0] byte_data, rd_data;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;

  lcd_bus_responder #(
    .E_MIN_HIGH (E_MIN),
    .CMD_BUSY   (CMD_B),
    .CLEAR_BUSY (CLR_B)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .LCD_E       (LCD_E),
    .LCD_RS      (LCD_RS),
    .LCD_RW      (LCD_RW),
    .SF_D        (SF_D),
    .mode4       (mode4),
    .busy        (busy),
    .disp_on     (disp_on),
    .cursor_addr (cursor_addr),
    .byte_valid  (byte_valid),
    .byte_rs     (byte_rs),
    .byte_data   (byte_data),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .proto_err   (proto_err),
    .timing_err  (timing_err)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic send_nib(input logic rs, input logic [3:0] d, input int hi, input logic rw);
    LCD_RS = rs;
    SF_D   = d;
    LCD_RW = rw;
    LCD_E  = 1'b1;
    repeat (hi) tick();
    LCD_E = 1'b0;
    tick();
    LCD_RW = 1'b0;
  endtask

  task automatic send_byte(input logic rs, input logic [7:0] b);
    send_nib(rs, b[7:4], E_MIN, 1'b0);
    send_nib(rs, b[3:0], E_MIN, 1'b0);
  endtask

  task automatic wait_idle(output int c);
    c = 0;
    while (busy && (c < IDLE_TO)) begin
      tick();
      c++;
    end
    if (busy) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic cmd(input logic rs, input logic [7:0] b);
    int c;
    send_byte(rs, b);
    wait_idle(c);
  endtask

  task automatic check_rd(input string tag, input logic [6:0] a, input logic [7:0] exp);
    rd_addr = a;
    tick();
    check(tag, 32'(rd_data), 32'(exp));
  endtask

  task automatic do_reset();
    Reset  = 1'b1;
    LCD_E  = 1'b0;
    LCD_RS = 1'b0;
    LCD_RW = 1'b0;
    SF_D   = 4'h0;
    repeat (3) tick();
    Reset = 1'b0;
  endtask

  task automatic do_init();
    int c;
    wait_idle(c);
    for (int i = 0; i < 3; i++) begin
      send_nib(1'b0, 4'h3, E_MIN, 1'b0);
      wait_idle(c);
    end
    send_nib(1'b0, 4'h2, E_MIN, 1'b0);
    wait_idle(c);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rd_addr = 7'h00;
    do_reset();
    check("rst_mode4", 32'(mode4), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_cursor", 32'(cursor_addr), 32'h00);
    check("rst_bv", 32'(byte_valid), 32'd0);
    check("rst_disp", 32'(disp_on), 32'd0);
    check("rst_perr", 32'(proto_err), 32'd0);
    check("rst_terr", 32'(timing_err), 32'd0);
    check("rst_rdata", 32'(rd_data), 32'h20);
    wait_idle(cyc);
    check("rst_busy_len", 32'(cyc), 32'd80);
    check_rd("clr_27", 7'h27, 8'h20);
    check_rd("clr_67", 7'h67, 8'h20);

    // Init handshake
    for (int i = 0; i < 3; i++) begin
      send_nib(1'b0, 4'h3, E_MIN, 1'b0);
      if (i == 0) check("init_busy", 32'(busy), 32'd1);
      wait_idle(cyc);
    end
    check("init_mode4_pre", 32'(mode4), 32'd0);
    send_nib(1'b0, 4'h2, E_MIN, 1'b0);
    check("init_mode4", 32'(mode4), 32'd1);
    wait_idle(cyc);
    check("init_perr", 32'(proto_err), 32'd0);
    check("init_terr", 32'(timing_err), 32'd0);

    // Command sequence
    send_byte(1'b0, 8'h28);
    check("func_bv", 32'(byte_valid), 32'd1);
    check("func_data", 32'(byte_data), 32'h28);
    check("func_rs", 32'(byte_rs), 32'd0);
    tick();
    check("func_bv_pulse", 32'(byte_valid), 32'd0);
    wait_idle(cyc);
    cmd(1'b0, 8'h06);
    cmd(1'b0, 8'h0C);
    check("disp_on", 32'(disp_on), 32'd1);
    send_byte(1'b0, 8'h01);
    wait_idle(cyc);
    check("clear_busy_len", 32'(cyc), 32'(CLR_B));
    check("clear_cursor", 32'(cursor_addr), 32'h00);
    cmd(1'b0, 8'h80);
    send_byte(1'b1, 8'h48);
    check("data_rs", 32'(byte_rs), 32'd1);
    check("data_byte", 32'(byte_data), 32'h48);
    wait_idle(cyc);
    check("data_cursor", 32'(cursor_addr), 32'h01);
    check_rd("rd_00", 7'h00, 8'h48);
    check_rd("rd_01", 7'h01, 8'h20);

    // Address wrap cases
    cmd(1'b0, 8'hA7);
    check("set_27", 32'(cursor_addr), 32'h27);
    cmd(1'b1, 8'h41);
    check("wrap_27_40", 32'(cursor_addr), 32'h40);
    check_rd("rd_27", 7'h27, 8'h41);
    cmd(1'b0, 8'h04);
    cmd(1'b0, 8'h80);
    cmd(1'b1, 8'h42);
    check("wrap_00_67", 32'(cursor_addr), 32'h67);
    check_rd("rd_00_b", 7'h00, 8'h42);
    cmd(1'b0, 8'hC0);
    cmd(1'b1, 8'h43);
    check("wrap_40_27", 32'(cursor_addr), 32'h27);
    check_rd("rd_40", 7'h40, 8'h43);
    cmd(1'b0, 8'h06);
    cmd(1'b0, 8'h90);
    rd_addr = 7'h10;
    send_byte(1'b1, 8'h55);
    check("rw_same_old", 32'(rd_data), 32'h20);
    tick();
    check("rw_same_new", 32'(rd_data), 32'h55);
    wait_idle(cyc);
    cmd(1'b0, 8'hE7);
    cmd(1'b1, 8'h5A);
    check("wrap_67_00", 32'(cursor_addr), 32'h00);
    check_rd("rd_67", 7'h67, 8'h5A);
    check("mid_perr", 32'(proto_err), 32'd0);
    check("mid_terr", 32'(timing_err), 32'd0);

    // Short E pulse is discarded
    send_nib(1'b0, 4'h0, 5, 1'b0);
    check("short_terr", 32'(timing_err), 32'd1);
    check("short_bv", 32'(byte_valid), 32'd0);
    send_byte(1'b0, 8'h08);
    check("short_then_bv", 32'(byte_valid), 32'd1);
    check("short_then_data", 32'(byte_data), 32'h08);
    check("short_then_disp", 32'(disp_on), 32'd0);
    wait_idle(cyc);

    // Reset clears errors and buffer; strobe during busy
    do_reset();
    check("rst2_terr", 32'(timing_err), 32'd0);
    check("rst2_mode4", 32'(mode4), 32'd0);
    check("rst2_cursor", 32'(cursor_addr), 32'h00);
    wait_idle(cyc);
    check_rd("rst2_rd_00", 7'h00, 8'h20);
    do_init();
    check("rst2_init", 32'(mode4), 32'd1);
    send_byte(1'b0, 8'h0C);
    repeat (100) tick();
    check("busy_hold", 32'(busy), 32'd1);
    check("busy_terr_pre", 32'(timing_err), 32'd0);
    send_byte(1'b0, 8'h08);
    check("busy_terr", 32'(timing_err), 32'd1);
    check("busy_bv", 32'(byte_valid), 32'd1);
    check("busy_data", 32'(byte_data), 32'h08);
    check("busy_disp", 32'(disp_on), 32'd0);
    wait_idle(cyc);
    check("illegal_perr_pre", 32'(proto_err), 32'd0);
    cmd(1'b0, 8'hF5);
    check("illegal_perr", 32'(proto_err), 32'd1);
    check("illegal_clamp", 32'(cursor_addr), 32'h40);

    // Protocol errors
    do_reset();
    check("rst3_perr", 32'(proto_err), 32'd0);
    do_init();
    send_nib(1'b0, 4'h0, E_MIN, 1'b1);
    check("rw_perr", 32'(proto_err), 32'd1);
    check("rw_bv", 32'(byte_valid), 32'd0);
    send_byte(1'b0, 8'h0C);
    check("rw_then_data", 32'(byte_data), 32'h0C);
    check("rw_then_disp", 32'(disp_on), 32'd1);
    wait_idle(cyc);
    do_reset();
    check("rst4_perr", 32'(proto_err), 32'd0);
    wait_idle(cyc);
    send_nib(1'b0, 4'h5, E_MIN, 1'b0);
    check("init_bad_perr", 32'(proto_err), 32'd1);
    check("init_bad_mode4", 32'(mode4), 32'd0);
    do_init();
    check("init_after_bad", 32'(mode4), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
